// File: rtl/message_slicer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | message_slicer: buffers N_SLICES*WIDTH-bit messages in a circular FIFO  |
// | and emits them MSB-first, one WIDTH-bit slice per clock.                |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module message_slicer #(
  parameter int N_SLICES          = 2,
  parameter int WIDTH             = 32,
  parameter int BUFFER_LENGTH     = 8,
  parameter int LOG_BUFFER_LENGTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SLICES*WIDTH-1:0] in_data,
  input  logic                      in_nd,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_nd,
  output logic                      error
);

  localparam int MSG_W   = N_SLICES * WIDTH;
  localparam int SLICE_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam int PTR_W   = LOG_BUFFER_LENGTH;
  localparam int CNT_W   = LOG_BUFFER_LENGTH + 1;

  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(N_SLICES - 1);
  localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(BUFFER_LENGTH);

  logic [MSG_W-1:0]   mem_q [BUFFER_LENGTH];
  logic [MSG_W-1:0]   mem_d [BUFFER_LENGTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SLICE_W-1:0] slice_cnt_q, slice_cnt_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_nd_q, out_nd_d;
  logic               error_q, error_d;

  logic [MSG_W-1:0]   w_head;
  logic [WIDTH-1:0]   w_slice;
  logic               w_not_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_wr;
  logic               w_overflow;

  always_comb begin
    w_head  = mem_q[rd_ptr_q];
    w_slice = '0;
    // Slice 0 lives in the most significant WIDTH bits of the message.
    for (int i = 0; i < N_SLICES; i++) begin
      if (slice_cnt_q == SLICE_W'(i)) begin
        w_slice = w_head[(N_SLICES-1-i)*WIDTH +: WIDTH];
      end
    end

    w_not_empty = (count_q != '0);
    w_full      = (count_q == FULL_COUNT);
    w_pop       = w_not_empty && (slice_cnt_q == LAST_SLICE);
    // A full buffer still accepts a write when the head is popped on the same edge.
    w_wr        = in_nd && (!w_full || w_pop);
    w_overflow  = in_nd && w_full && !w_pop;
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    slice_cnt_d = slice_cnt_q;
    out_data_d  = out_data_q;
    out_nd_d    = w_not_empty;
    error_d     = error_q | w_overflow;

    if (w_wr) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (w_not_empty) begin
      out_data_d = w_slice;
      if (w_pop) begin
        slice_cnt_d = '0;
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      end else begin
        slice_cnt_d = slice_cnt_q + SLICE_W'(1);
      end
    end

    case ({w_wr, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: the pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      slice_cnt_q <= '0;
      out_data_q  <= '0;
      out_nd_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      slice_cnt_q <= slice_cnt_d;
      out_data_q  <= out_data_d;
      out_nd_q    <= out_nd_d;
      error_q     <= error_d;
    end
  end

  assign out_data = out_data_q;
  assign out_nd   = out_nd_q;
  assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_message_slicer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_message_slicer: directed self-checking bench for message_slicer.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_message_slicer;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_data;
  logic        in_nd;
  logic [31:0] out_data;
  logic        out_nd;
  logic        error;

  int checks;
  int failures;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  message_slicer #(2, 32, 8, 3) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_nd    (in_nd),
    .out_data (out_data),
    .out_nd   (out_nd),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic record();
    if (out_nd) got_q.push_back(out_data);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_nd = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    in_nd   = 1'b1;
    in_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    checks++;
    if (out_nd !== 1'b0 || out_data !== 32'h0 || error !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: out_nd=%b out_data=%h error=%b, want 0/00000000/0",
               out_nd, out_data, error);
    end
    rst_n = 1'b1;
    in_nd = 1'b0;
    tick();
    tick();
    checks++;
    if (out_nd !== 1'b0) begin
      failures++;
      $display("FAIL reset_ignores_in_nd: out_nd=%b, want 0", out_nd);
    end
  endtask

  task automatic test_single();
    do_reset();
    in_data = 64'h1111_2222_3333_4444;
    in_nd   = 1'b1;
    tick();
    in_nd   = 1'b0;
    in_data = 64'hDEAD_BEEF_DEAD_BEEF;
    checks++;
    if (out_nd !== 1'b0) begin
      failures++;
      $display("FAIL single_write_edge: out_nd=%b, want 0", out_nd);
    end
    tick();
    checks++;
    if (out_nd !== 1'b1 || out_data !== 32'h1111_2222) begin
      failures++;
      $display("FAIL single_slice0: out_nd=%b out_data=%h, want 1/11112222", out_nd, out_data);
    end
    tick();
    checks++;
    if (out_nd !== 1'b1 || out_data !== 32'h3333_4444) begin
      failures++;
      $display("FAIL single_slice1: out_nd=%b out_data=%h, want 1/33334444", out_nd, out_data);
    end
    tick();
    checks++;
    if (out_nd !== 1'b0 || out_data !== 32'h3333_4444) begin
      failures++;
      $display("FAIL single_idle_hold: out_nd=%b out_data=%h, want 0/33334444", out_nd, out_data);
    end
    tick();
    checks++;
    if (out_nd !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL single_stays_idle: out_nd=%b error=%b, want 0/0", out_nd, error);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [4];
    want[0] = 32'hAAAA_AAAA;
    want[1] = 32'h0000_0001;
    want[2] = 32'hBBBB_BBBB;
    want[3] = 32'h0000_0002;
    do_reset();
    in_nd   = 1'b1;
    in_data = 64'hAAAA_AAAA_0000_0001;
    tick();
    in_data = 64'hBBBB_BBBB_0000_0002;
    tick();
    in_nd   = 1'b0;
    in_data = 64'h0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_nd !== 1'b1 || out_data !== want[k]) begin
        failures++;
        $display("FAIL b2b_slice%0d: out_nd=%b out_data=%h, want 1/%h", k, out_nd, out_data, want[k]);
      end
      tick();
    end
    checks++;
    if (out_nd !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: out_nd=%b error=%b, want 0/0", out_nd, error);
    end
  endtask

  // 20 consecutive writes: messages 15, 17 and 19 arrive with the buffer
  // full and no pop, so they are dropped; error rises on the 16th edge.
  task automatic test_overflow();
    logic exp_err;
    do_reset();
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      in_nd   = 1'b1;
      in_data = {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
      tick();
      record();
      exp_err = (i >= 15);
      checks++;
      if (error !== exp_err) begin
        failures++;
        $display("FAIL overflow_error_edge%0d: error=%b, want %b", i + 1, error, exp_err);
      end
    end
    in_nd = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      record();
    end
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: error=%b, want 1", error);
    end
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(32'h1000_0000 + 32'(i));
      exp_q.push_back(32'h2000_0000 + 32'(i));
    end
    exp_q.push_back(32'h1000_0010);
    exp_q.push_back(32'h2000_0010);
    exp_q.push_back(32'h1000_0012);
    exp_q.push_back(32'h2000_0012);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL overflow_count: slices=%0d, want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL overflow_slice%0d: got %h, want %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  // Entered with error=1 left over from the overflow run.
  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin
      in_nd   = 1'b1;
      in_data = {32'h5000_0000 + 32'(i), 32'h6000_0000 + 32'(i)};
      tick();
    end
    rst_n   = 1'b0;
    in_data = 64'hFFFF_0000_FFFF_0000;
    tick();
    rst_n = 1'b1;
    in_nd = 1'b0;
    checks++;
    if (out_nd !== 1'b0 || error !== 1'b0 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL midreset_state: out_nd=%b error=%b out_data=%h, want 0/0/00000000",
               out_nd, error, out_data);
    end
    tick();
    tick();
    tick();
    checks++;
    if (out_nd !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_residue: out_nd=%b, want 0", out_nd);
    end
    in_nd   = 1'b1;
    in_data = 64'h7777_8888_9999_AAAA;
    tick();
    in_nd = 1'b0;
    tick();
    checks++;
    if (out_nd !== 1'b1 || out_data !== 32'h7777_8888) begin
      failures++;
      $display("FAIL midreset_next_slice0: out_nd=%b out_data=%h, want 1/77778888", out_nd, out_data);
    end
    tick();
    checks++;
    if (out_nd !== 1'b1 || out_data !== 32'h9999_AAAA) begin
      failures++;
      $display("FAIL midreset_next_slice1: out_nd=%b out_data=%h, want 1/9999aaaa", out_nd, out_data);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    got_q.delete();
    for (int j = 0; j < 30; j++) begin
      in_nd   = 1'b1;
      in_data = {32'hC000_0000 + 32'(j), 32'hD000_0000 + 32'(j)};
      tick();
      record();
      in_nd = 1'b0;
      tick();
      record();
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      record();
    end
    checks++;
    if (got_q.size() != 60) begin
      failures++;
      $display("FAIL wrap_count: slices=%0d, want 60", got_q.size());
    end
    for (int k = 0; k < 60 && k < got_q.size(); k++) begin
      logic [31:0] w;
      w = (k % 2 == 0) ? 32'hC000_0000 + 32'(k / 2) : 32'hD000_0000 + 32'(k / 2);
      checks++;
      if (got_q[k] !== w) begin
        failures++;
        $display("FAIL wrap_slice%0d: got %h, want %h", k, got_q[k], w);
      end
    end
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL wrap_error: error=%b, want 0", error);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_nd    = 1'b0;
    in_data  = 64'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
